// File: rtl/noc_flit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : noc_flit_trace_buffer
// Brief    : On-chip NoC flit capture buffer with STOP / WRAP / TRIG modes,
//            round-robin channel arbitration and saturating drop accounting.
// Revision : 1.0
// ============================================================================
module noc_flit_trace_buffer #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int CH_W   = 3,
    parameter int DROP_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_en,
    input  logic [1:0]                    cfg_mode,
    input  logic [CH_W-1:0]               cfg_trig_ch,
    input  logic [NUM_CH-1:0]             mon_valid,
    input  logic [NUM_CH*DATA_W-1:0]      mon_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [TS_W+CH_W+DATA_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]        fill_level,
    output logic [DROP_W-1:0]             drop_cnt,
    output logic [1:0]                    state_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = TS_W + CH_W + DATA_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_WRAP = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    localparam logic [AW:0]       FULL_LVL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]       NEAR_FULL  = (AW+1)'(DEPTH - 1);
    localparam logic [DROP_W-1:0] DROP_MAX   = {DROP_W{1'b1}};
    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

    logic [1:0]        r_state;
    logic              r_en_q;
    logic [TS_W-1:0]   r_ts;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_fill;
    logic [DROP_W-1:0] r_drop;
    logic [CH_W-1:0]   r_rr_next;
    logic [REC_W-1:0]  r_mem [DEPTH];

    logic              w_arm;
    logic              w_disable;
    logic              w_wrap;
    logic              w_full;
    logic              w_pop;
    logic              w_win_found;
    logic [CH_W-1:0]   w_win_idx;
    logic [DATA_W-1:0] w_win_data;
    logic              w_trig_hit;
    logic [DATA_W-1:0] w_trig_data;
    logic              w_trig_fire;
    logic              w_run_cap;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_overwrite;
    logic              w_done;
    logic [CH_W-1:0]   w_push_ch;
    logic [DATA_W-1:0] w_push_data;
    logic [3:0]        w_nvalid;
    logic [3:0]        w_drop_inc;
    logic [DROP_W+3:0] w_drop_sum;
    logic [DROP_W-1:0] w_drop_nxt;
    logic [AW:0]       w_fill_nxt;
    logic [1:0]        w_state_nxt;

    assign w_arm     = (r_state == ST_IDLE) && cfg_en && !r_en_q;
    assign w_disable = (r_state != ST_IDLE) && !cfg_en;
    assign w_wrap    = (cfg_mode == MODE_WRAP);
    assign w_full    = (r_fill == FULL_LVL);
    assign w_pop     = rd_valid && rd_ready && !w_arm;

    // Round-robin search starting at r_rr_next; first valid channel wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_win_found && mon_valid[i] &&
                    (i == ((int'(r_rr_next) + k) % NUM_CH))) begin
                    w_win_found = 1'b1;
                    w_win_idx   = CH_W'(i);
                end
            end
        end
    end

    // Channel data muxes; an out-of-range trigger channel simply never matches.
    always_comb begin
        w_win_data  = '0;
        w_trig_data = '0;
        w_trig_hit  = 1'b0;
        w_nvalid    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win_idx == CH_W'(i))
                w_win_data = mon_data[i*DATA_W +: DATA_W];
            if (cfg_trig_ch == CH_W'(i)) begin
                w_trig_data = mon_data[i*DATA_W +: DATA_W];
                w_trig_hit  = mon_valid[i];
            end
            w_nvalid = w_nvalid + 4'(mon_valid[i]);
        end
    end

    assign w_trig_fire = (r_state == ST_ARMED) && cfg_en && w_trig_hit;
    assign w_run_cap   = (r_state == ST_RUN) && cfg_en;
    assign w_push_req  = w_trig_fire || (w_run_cap && w_win_found);
    assign w_push_ch   = w_trig_fire ? cfg_trig_ch : w_win_idx;
    assign w_push_data = w_trig_fire ? w_trig_data : w_win_data;
    assign w_push_ok   = w_push_req && (!w_full || w_pop || w_wrap);
    assign w_overwrite = w_push_ok && w_full && !w_pop;
    assign w_done      = !w_wrap && w_push_ok && !w_pop && (r_fill == NEAR_FULL);

    // Losers count as drops; so does a refused push or an overwritten record.
    always_comb begin
        w_drop_inc = '0;
        if (w_run_cap)
            w_drop_inc = w_nvalid - {3'b0, w_push_ok} + {3'b0, w_overwrite};
        w_drop_sum = {4'b0, r_drop} + (DROP_W+4)'(w_drop_inc);
        if (w_drop_sum > {4'b0, DROP_MAX})
            w_drop_nxt = DROP_MAX;
        else
            w_drop_nxt = w_drop_sum[DROP_W-1:0];
    end

    always_comb begin
        w_fill_nxt = r_fill;
        if (w_push_ok && !w_overwrite && !w_pop)
            w_fill_nxt = r_fill + 1'b1;
        else if (w_pop && !w_push_ok)
            w_fill_nxt = r_fill - 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_disable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_arm)
                              w_state_nxt = (cfg_mode == MODE_TRIG) ? ST_ARMED : ST_RUN;
                ST_ARMED: if (w_trig_fire)
                              w_state_nxt = w_done ? ST_DONE : ST_RUN;
                ST_RUN:   if (w_done)
                              w_state_nxt = ST_DONE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_en_q    <= 1'b0;
            r_ts      <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fill    <= '0;
            r_drop    <= '0;
            r_rr_next <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_en_q  <= cfg_en;
            if (w_arm) begin
                r_ts      <= '0;
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_fill    <= '0;
                r_drop    <= '0;
                r_rr_next <= '0;
            end else begin
                if (r_state == ST_ARMED || r_state == ST_RUN)
                    r_ts <= r_ts + 1'b1;
                if (w_push_ok)
                    r_wptr <= r_wptr + 1'b1;
                if (w_pop || w_overwrite)
                    r_rptr <= r_rptr + 1'b1;
                if (w_push_req)
                    r_rr_next <= (w_push_ch == LAST_CH) ? '0 : w_push_ch + 1'b1;
                r_fill <= w_fill_nxt;
                r_drop <= w_drop_nxt;
            end
        end
    end

    // Storage needs no reset: rd_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wptr] <= {r_ts, w_push_ch, w_push_data};
    end

    assign rd_valid   = (r_fill != '0);
    assign rd_data    = rd_valid ? r_mem[r_rptr] : '0;
    assign fill_level = r_fill;
    assign drop_cnt   = r_drop;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_noc_flit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_flit_trace_buffer
// Brief    : Directed self-checking bench; expected records queued at stimulus.
// Revision : 1.0
// ============================================================================
module tb_noc_flit_trace_buffer;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int CH_W   = 3;
    localparam int DROP_W = 16;
    localparam int REC_W  = TS_W + CH_W + DATA_W;
    localparam int FW     = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     cfg_en;
    logic [1:0]               cfg_mode;
    logic [CH_W-1:0]          cfg_trig_ch;
    logic [NUM_CH-1:0]        mon_valid;
    logic [NUM_CH*DATA_W-1:0] mon_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic [REC_W-1:0]         rd_data;
    logic [FW-1:0]            fill_level;
    logic [DROP_W-1:0]        drop_cnt;
    logic [1:0]               state_o;

    int n_vec = 0;
    int n_err = 0;
    logic [REC_W-1:0] exp_q[$];

    noc_flit_trace_buffer #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .TS_W(TS_W), .CH_W(CH_W), .DROP_W(DROP_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_trig_ch(cfg_trig_ch),
        .mon_valid(mon_valid), .mon_data(mon_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .fill_level(fill_level), .drop_cnt(drop_cnt), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] rec(input int ts, input int ch, input logic [DATA_W-1:0] d);
        return {TS_W'(ts), CH_W'(ch), d};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] mode);
        cfg_en = 1'b0;
        tick();
        cfg_mode = mode;
        cfg_en   = 1'b1;
        tick();
    endtask

    task automatic set_ch(input int ch, input logic [DATA_W-1:0] d);
        mon_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic drain(input string tag);
        rd_ready = 1'b1;
        for (int c = 0; c < 64 && exp_q.size() > 0; c++) begin
            if (rd_valid)
                check(tag, rd_data, exp_q.pop_front());
            tick();
        end
        rd_ready = 1'b0;
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_empty"}, rd_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_en = 1'b0; cfg_mode = 2'd0; cfg_trig_ch = '0;
        mon_valid = '0; mon_data = '0; rd_ready = 1'b0;
        repeat (3) tick();
        check("rst_state", state_o, 0);
        check("rst_fill", fill_level, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // STOP: channel 2 every cycle; 17th flit arrives after DONE
        arm(2'd0);
        check("stop_run", state_o, 2);
        for (int c = 0; c < 17; c++) begin
            mon_valid = 5'b00100;
            set_ch(2, 64'(c));
            if (c < 16) exp_q.push_back(rec(c, 2, 64'(c)));
            tick();
            if (c == 14) check("stop_run_c14", state_o, 2);
            if (c == 15) check("stop_done_c15", state_o, 3);
        end
        mon_valid = '0;
        check("stop_fill", fill_level, 16);
        check("stop_drop", drop_cnt, 0);
        check("stop_state", state_o, 3);
        cfg_en = 1'b0;
        tick();
        check("disable_idle", state_o, 0);
        check("disable_keep", fill_level, 16);
        drain("stop_drain");

        // WRAP: 20 flits into 16 entries
        arm(2'd1);
        for (int c = 0; c < 20; c++) begin
            mon_valid = 5'b00001;
            set_ch(0, 64'(100 + c));
            if (c >= 4) exp_q.push_back(rec(c, 0, 64'(100 + c)));
            tick();
        end
        mon_valid = '0;
        check("wrap_fill", fill_level, 16);
        check("wrap_drop", drop_cnt, 4);
        check("wrap_state", state_o, 2);
        drain("wrap_drain");

        // Round robin with all channels valid
        arm(2'd0);
        check("arm_clr_drop", drop_cnt, 0);
        for (int c = 0; c < 4; c++) begin
            mon_valid = '1;
            for (int ch = 0; ch < NUM_CH; ch++) set_ch(ch, 64'(32'h1000 + ch));
            exp_q.push_back(rec(c, c, 64'(32'h1000 + c)));
            tick();
        end
        mon_valid = '0;
        check("rr_drop", drop_cnt, 16);
        check("rr_fill", fill_level, 4);
        drain("rr_drain");

        // TRIG on channel 3
        cfg_trig_ch = 3'd3;
        arm(2'd2);
        check("trig_armed", state_o, 1);
        for (int c = 0; c < 10; c++) begin
            mon_valid = 5'b00010;
            set_ch(1, 64'(32'h200 + c));
            tick();
        end
        check("trig_wait_state", state_o, 1);
        check("trig_wait_fill", fill_level, 0);
        check("trig_wait_drop", drop_cnt, 0);
        mon_valid = 5'b01010;
        set_ch(3, 64'h0ABC);
        exp_q.push_back(rec(10, 3, 64'h0ABC));
        tick();
        mon_valid = '0;
        check("trig_state", state_o, 2);
        check("trig_drop", drop_cnt, 0);
        check("trig_fill", fill_level, 1);
        drain("trig_drain");

        // Trigger channel beyond NUM_CH never fires
        cfg_trig_ch = 3'd7;
        arm(2'd2);
        mon_valid = '1;
        repeat (3) tick();
        mon_valid = '0;
        check("trig_oob_state", state_o, 1);
        check("trig_oob_fill", fill_level, 0);

        // Full in STOP with simultaneous push and pop
        arm(2'd1);
        for (int c = 0; c < 16; c++) begin
            mon_valid = 5'b10000;
            set_ch(4, 64'(32'h300 + c));
            if (c >= 1) exp_q.push_back(rec(c, 4, 64'(32'h300 + c)));
            tick();
        end
        check("full_fill", fill_level, 16);
        check("full_state", state_o, 2);
        cfg_mode = 2'd0;
        set_ch(4, 64'hFEED);
        rd_ready = 1'b1;
        check("full_pop_head", rd_data, rec(0, 4, 64'h300));
        exp_q.push_back(rec(16, 4, 64'hFEED));
        tick();
        rd_ready = 1'b0;
        check("pp_fill", fill_level, 16);
        check("pp_state", state_o, 2);
        check("pp_drop", drop_cnt, 0);
        tick();
        mon_valid = '0;
        check("full_nopop_drop", drop_cnt, 1);
        check("full_nopop_fill", fill_level, 16);
        check("full_nopop_state", state_o, 2);
        drain("full_drain");

        // Asynchronous reset mid-RUN with 5 entries
        arm(2'd0);
        for (int c = 0; c < 5; c++) begin
            mon_valid = 5'b00100;
            tick();
        end
        mon_valid = '0;
        check("pre_rst_fill", fill_level, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state_o, 0);
        check("arst_fill", fill_level, 0);
        check("arst_valid", rd_valid, 0);
        check("arst_data", rd_data, 0);
        check("arst_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        cfg_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_flit_trace_buffer.md
Name: noc_flit_trace_buffer

Overview:
- Synthesisable, parametrised on-chip capture buffer for dynamic-network traffic; successor to the simulation-only stimulus dumper.
- Monitors NUM_CH valid/data channel pairs (router ports N/E/S/W/P or any subset), records flits with timestamp and channel ID into a DEPTH-entry buffer, and drains them over a valid/ready readout port.
- Adds stop-when-full, wrap (overwrite-oldest) and triggered capture modes, plus drop accounting.
- Sits beside a tile's dynamic node, or in the chip bridge for debug readout.

Parameters:
NUM_CH, 5, number of monitored channels (1..8)
DATA_W, 64, flit width
DEPTH, 16, buffer entries; power of two, >=2
TS_W, 16, timestamp width
CH_W, 3, channel-ID field width; must satisfy 2**CH_W >= NUM_CH
DROP_W, 16, drop counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_en  in  1  capture enable (level)
cfg_mode  in  2  0=STOP, 1=WRAP, 2=TRIG (trigger then STOP); 3 behaves as 0
cfg_trig_ch  in  CH_W  trigger channel for TRIG mode
mon_valid  in  NUM_CH  per-channel flit valid
mon_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
rd_valid  out  1  record available
rd_ready  in  1  consumer accepts record
rd_data  out  TS_W+CH_W+DATA_W  record {ts, ch_id, data}, timestamp in the MSBs
fill_level  out  $clog2(DEPTH)+1  entries held
drop_cnt  out  DROP_W  saturating count of uncaptured flits
state_o  out  2  0=IDLE, 1=ARMED, 2=RUN, 3=DONE

Behaviour:
- Reset (asynchronous, active-low on rst_n): state IDLE; pointers, fill_level, drop_cnt and timestamp all 0; rd_valid=0; rd_data=0.
- Arm:
  - cfg_en 0->1 while IDLE clears the buffer, drop_cnt and timestamp.
  - Next state is ARMED for mode 2, otherwise RUN.
  - cfg_en=1 held in IDLE does not re-arm; a rising edge is required.
- Timestamp:
  - Counts +1 every cycle in ARMED and RUN; holds in IDLE and DONE.
  - Wraps modulo 2**TS_W. First RUN cycle after arm uses ts=0.
- Capture arbitration (RUN only, and the trigger cycle):
  - At most one flit written per cycle.
  - Round-robin over channels with mon_valid=1, starting from the channel after the last winner. Pointer resets to channel 0.
  - Winner record = {ts, winner index, winner data}, written the same edge.
  - Every other valid channel in that cycle adds 1 to drop_cnt; drop_cnt saturates at all-ones.
- ARMED:
  - When mon_valid[cfg_trig_ch]=1, the trigger channel wins unconditionally and is captured that cycle.
  - Other valid channels are not counted as drops.
  - State goes to RUN.
  - cfg_trig_ch >= NUM_CH never triggers.
- Full handling:
  - STOP/TRIG: a push that makes fill_level==DEPTH moves the state to DONE. While full in RUN, the flit that would have been written counts as a drop.
  - WRAP: a push while full with no pop overwrites the oldest entry; read pointer advances; fill_level stays DEPTH; drop_cnt +1.
- Readout:
  - rd_valid = (fill_level != 0). rd_data is the oldest entry (registered; combinational from storage is allowed).
  - Pop occurs on rd_valid & rd_ready. Readout is allowed in every state.
  - Simultaneous push and pop: fill_level unchanged; when full in STOP mode the push succeeds, no drop is counted, and the state does not go to DONE.
  - rd_data is stable while rd_valid=1 and rd_ready=0, except in WRAP overwrite, where the head changes.
- Disable: cfg_en=0 in ARMED, RUN or DONE -> IDLE next cycle. Buffer contents and drop_cnt are retained for readout.
- Pointers: log2(DEPTH) bits, natural wrap.

Test Plan:
- Reset mid-RUN with 5 entries held -> all outputs 0 and state_o=0 immediately on rst_n fall, asynchronously.
- STOP, DEPTH=16, channel 2 valid every cycle with data=cycle index, no reads -> 16 records with ts 0..15 and ch=2; state DONE on cycle 16; drop_cnt=0. The 17th flit is not captured: state is already DONE, so no drop.
- WRAP, DEPTH=16, 20 flits on channel 0, no reads -> fill_level=16, drop_cnt=4; draining yields ts 4..19 in order.
- All 5 channels valid for 4 cycles in RUN -> winners 0,1,2,3 in that order; drop_cnt=16.
- TRIG with cfg_trig_ch=3, channel 1 valid for 10 cycles, then channels 1 and 3 valid together -> first record is ch=3 with ts=10; drop_cnt=0; state RUN.
- Full in STOP mode with rd_ready=1 and a push in the same cycle -> fill_level stays 16; state stays RUN; popped record is the oldest; drop_cnt unchanged.
